// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word reads, buffers returned words and
// presents them with decoded field slices. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    // Drop counter is wide so a burst of redirects ignoring credit can never wrap it.
    localparam int DW = 16;
    localparam int SW = DW + 2;

    typedef enum logic [1:0] {
        BOOT,
        RUN
`ifdef FETCH_MISALIGN_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]   pc_reg;
    logic [31:0]   buf_instr_mem [BUF_DEPTH];
    logic [31:0]   buf_pc_mem    [BUF_DEPTH];
    logic [31:0]   pend_pc_mem   [BUF_DEPTH];
    logic [PW-1:0] buf_rd_ptr_reg, buf_wr_ptr_reg;
    logic [PW-1:0] pend_rd_ptr_reg, pend_wr_ptr_reg;
    logic [CW-1:0] buf_cnt_reg, live_cnt_reg;
    logic [DW-1:0] drop_cnt_reg;

    logic [31:0]   redir_pc_aligned;
    logic          redir_bad, redir_ok;
    logic          pop, push, acc, credit_ok;
    logic [SW-1:0] credit_used;
    logic [PW-1:0] pend_waddr;

    assign redir_pc_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_reg;
    assign redir_bad   = redirect && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault_reg;
`else
    logic unused_lowbits;
    assign unused_lowbits = ^redirect_pc[1:0];
    assign redir_bad      = 1'b0;
    assign fetch_fault    = 1'b0;
`endif

    assign redir_ok = redirect && !redir_bad;

    assign if_valid = (buf_cnt_reg != '0);
    assign pop      = if_valid && id_ready && !redirect;
    assign push     = imem_rvalid && !redirect && (drop_cnt_reg == '0);
    assign acc      = imem_req && imem_gnt;

    // A same-cycle pop frees a slot before any new response can land, so it counts as credit.
    assign credit_used = SW'(drop_cnt_reg) + SW'(live_cnt_reg) + SW'(buf_cnt_reg);
    assign credit_ok   = credit_used < (SW'(BUF_DEPTH) + SW'(pop));

    assign pend_waddr = redirect ? '0 : pend_wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= BOOT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        imem_addr  = pc_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     imem_req   = credit_ok;
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT:    imem_req   = 1'b0;
`endif
            default: state_next = BOOT;
        endcase
        if (redirect) begin
            if (redir_bad) begin
                imem_req = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                state_next = HALT;
`endif
            end else begin
                imem_req   = 1'b1;
                imem_addr  = redir_pc_aligned;
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_mem[buf_wr_ptr_reg] <= imem_rdata;
            buf_pc_mem[buf_wr_ptr_reg]    <= pend_pc_mem[pend_rd_ptr_reg];
        end
        if (acc) pend_pc_mem[pend_waddr] <= imem_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            buf_rd_ptr_reg  <= '0;
            buf_wr_ptr_reg  <= '0;
            buf_cnt_reg     <= '0;
            pend_rd_ptr_reg <= '0;
            pend_wr_ptr_reg <= '0;
            live_cnt_reg    <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            if (acc)           pc_reg <= imem_addr + 32'd4;
            else if (redir_ok) pc_reg <= redir_pc_aligned;

            if (redirect) begin
                // Everything in flight becomes stale, including a response arriving right now.
                buf_rd_ptr_reg  <= '0;
                buf_wr_ptr_reg  <= '0;
                buf_cnt_reg     <= '0;
                pend_rd_ptr_reg <= '0;
                pend_wr_ptr_reg <= PW'(acc);
                live_cnt_reg    <= CW'(acc);
                drop_cnt_reg    <= DW'(SW'(drop_cnt_reg) + SW'(live_cnt_reg) - SW'(imem_rvalid));
            end else begin
                if (push) buf_wr_ptr_reg <= buf_wr_ptr_reg + PW'(1);
                if (pop)  buf_rd_ptr_reg <= buf_rd_ptr_reg + PW'(1);
                buf_cnt_reg <= buf_cnt_reg + CW'(push) - CW'(pop);

                if (acc)  pend_wr_ptr_reg <= pend_wr_ptr_reg + PW'(1);
                if (push) pend_rd_ptr_reg <= pend_rd_ptr_reg + PW'(1);
                live_cnt_reg <= live_cnt_reg + CW'(acc) - CW'(push);

                if (imem_rvalid && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - DW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)           fault_reg <= 1'b0;
        else if (redirect) fault_reg <= redir_bad;
    end
`endif

    assign if_instr = if_valid ? buf_instr_mem[buf_rd_ptr_reg] : 32'h0;
    assign if_pc    = if_valid ? buf_pc_mem[buf_rd_ptr_reg]    : 32'h0;
    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];
    assign funct7   = if_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of per-cycle vectors plus hand sequences for
// redirect, PC wrap, mid-run reset and the misaligned-redirect handling.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, id_ready;
    logic [31:0] if_instr, if_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    logic        imem_req2, imem_rvalid2, if_valid2, fetch_fault2;
    logic [31:0] imem_addr2, imem_rdata2, if_instr2, if_pc2;
    logic [6:0]  opcode2, funct72;
    logic [2:0]  funct32;
    logic [4:0]  rd2, rs12, rs22;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .if_valid(if_valid2), .id_ready(id_ready), .if_instr(if_instr2), .if_pc(if_pc2),
        .opcode(opcode2), .funct3(funct32), .funct7(funct72), .rd(rd2), .rs1(rs12), .rs2(rs22),
        .redirect(1'b0), .redirect_pc(32'h0), .fetch_fault(fetch_fault2)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    req_t        q[$];
    int          cyc = 0;
    int          lat = 1;
    logic        pend2_v = 1'b0;
    logic [31:0] pend2_a = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        imem_rvalid2 = pend2_v;
        imem_rdata2  = mem_word(pend2_a);
    endtask

    // Advances one clock: memory model records accepted requests and retires presented responses.
    task automatic tick();
        logic        acc, rv, acc2;
        logic [31:0] a, a2;
        acc  = imem_req && imem_gnt;
        a    = imem_addr;
        rv   = imem_rvalid;
        acc2 = imem_req2 && imem_gnt;
        a2   = imem_addr2;
        @(posedge clk);
        if (rst) begin
            q.delete();
            pend2_v = 1'b0;
        end else begin
            if (rv) void'(q.pop_front());
            if (acc) q.push_back('{a, cyc + lat});
            pend2_v = acc2;
            pend2_a = a2;
        end
        cyc++;
        @(negedge clk);
        drive_mem();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t tbl[18];
    int   waited;
    logic seen;

    initial begin
        rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_rvalid2 = 1'b0; imem_rdata2 = 32'h0;

        // Straight-line fetch, then reset and backpressure with id_ready low.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

        @(negedge clk);
        drive_mem();

        for (int i = 0; i < 18; i++) begin
            rst      = tbl[i].rst;
            id_ready = tbl[i].rdy;
            settle();
            $display("row %0d: rst=%0b rdy=%0b req=%0b addr=%h valid=%0b pc=%h", i, rst, id_ready,
                     imem_req, imem_addr, if_valid, if_pc);
            if (!tbl[i].rst) begin
                check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
                if (tbl[i].req) check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
                check($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(tbl[i].valid));
                if (tbl[i].valid) begin
                    check($sformatf("row%0d if_pc", i), if_pc, tbl[i].pc);
                    check($sformatf("row%0d if_instr", i), if_instr, mem_word(tbl[i].pc));
                end
                if (tbl[i].valid && tbl[i].pc == 32'h0) begin
                    check($sformatf("row%0d opcode", i), 32'(opcode), 32'h13);
                    check($sformatf("row%0d rd", i),     32'(rd),     32'h1);
                    check($sformatf("row%0d funct3", i), 32'(funct3), 32'h0);
                    check($sformatf("row%0d rs1", i),    32'(rs1),    32'h0);
                    check($sformatf("row%0d rs2", i),    32'(rs2),    32'hA);
                    check($sformatf("row%0d funct7", i), 32'(funct7), 32'h0);
                end
                if (!tbl[i].valid) check($sformatf("row%0d if_instr idle", i), if_instr, 32'h0);
            end
            tick();
        end

        // Redirect with two requests outstanding and 3-cycle memory latency.
        lat = 3;
        id_ready = 1'b1;
        do_reset();
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        settle();
        $display("redirect: req=%0b addr=%h", imem_req, imem_addr);
        check("redirect bypass req", 32'(imem_req), 32'h1);
        check("redirect bypass addr", imem_addr, 32'h100);
        tick();
        redirect = 1'b0;
        waited = 0; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (if_valid) begin
                seen = 1'b1;
                break;
            end
            waited++;
            tick();
        end
        $display("redirect: first valid after %0d idle cycles, pc=%h", waited, if_pc);
        check("redirect valid seen", 32'(seen), 32'h1);
        check("redirect first pc", if_pc, 32'h100);
        check("redirect first instr", if_instr, mem_word(32'h100));
        check("redirect idle cycles", 32'(waited), 32'd3);
        lat = 1;

        // PC wrap on the second instance.
        do_reset();
        settle();
        check("wrap boot req", 32'(imem_req2), 32'h0);
        tick(); settle();
        $display("wrap: addr=%h", imem_addr2);
        check("wrap addr0", imem_addr2, 32'hFFFF_FFF8);
        tick(); settle();
        $display("wrap: addr=%h", imem_addr2);
        check("wrap addr1", imem_addr2, 32'hFFFF_FFFC);
        tick(); settle();
        $display("wrap: addr=%h pc=%h", imem_addr2, if_pc2);
        check("wrap addr2", imem_addr2, 32'h0);
        check("wrap req2", 32'(imem_req2), 32'h1);
        check("wrap first pc", if_pc2, 32'hFFFF_FFF8);

        // Mid-run reset while an instruction is presented.
        do_reset();
        tick(); tick(); tick(); tick();
        settle();
        check("midrst valid before", 32'(if_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        $display("midrst: req=%0b valid=%0b instr=%h pc=%h", imem_req, if_valid, if_instr, if_pc);
        check("midrst req", 32'(imem_req), 32'h0);
        check("midrst valid", 32'(if_valid), 32'h0);
        check("midrst instr", if_instr, 32'h0);
        check("midrst pc", if_pc, 32'h0);
        check("midrst fault", 32'(fetch_fault), 32'h0);
        tick(); settle();
        check("midrst first req", 32'(imem_req), 32'h1);
        check("midrst first addr", imem_addr, 32'h0);

        // Misaligned redirect target.
        do_reset();
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        settle();
        $display("misalign: req=%0b addr=%h", imem_req, imem_addr);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap no bypass", 32'(imem_req), 32'h0);
        tick();
        redirect = 1'b0;
        settle();
        check("trap fault set", 32'(fetch_fault), 32'h1);
        check("trap halt req", 32'(imem_req), 32'h0);
        tick(); tick(); settle();
        check("trap halt req later", 32'(imem_req), 32'h0);
        check("trap halt valid", 32'(if_valid), 32'h0);
        check("trap fault held", 32'(fetch_fault), 32'h1);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        settle();
        check("trap resume req", 32'(imem_req), 32'h1);
        check("trap resume addr", imem_addr, 32'h200);
        tick();
        redirect = 1'b0;
        settle();
        check("trap fault cleared", 32'(fetch_fault), 32'h0);
        tick(); settle();
        check("trap resume valid", 32'(if_valid), 32'h1);
        check("trap resume pc", if_pc, 32'h200);
`else
        check("align bypass req", 32'(imem_req), 32'h1);
        check("align forced addr", imem_addr, 32'h100);
        check("align no fault", 32'(fetch_fault), 32'h0);
        tick();
        redirect = 1'b0;
        tick(); settle();
        check("align valid", 32'(if_valid), 32'h1);
        check("align pc", if_pc, 32'h100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
